// File: rtl/fft_stream_framer_if.sv
// Signal bundle between the sample source / config consumer and the framer.
// Handshake rule for all three channels (s_*, m_*, c_*): a transfer happens on
// the rising clock edge where tvalid and tready are both high; once a sender
// raises tvalid it holds tvalid and its payload stable until that transfer.
interface fft_stream_framer_if #(
    parameter int DATA_W = 16,
    parameter int OUT_W  = 16
);
    logic [DATA_W-1:0]  s_tdata;
    logic               s_tvalid;
    logic               s_tready;
    logic               s_tlast;
    logic [4:0]         cfg_log2n;
    logic               cfg_fwd;
    logic               cfg_update;
    logic [2*OUT_W-1:0] m_tdata;
    logic               m_tvalid;
    logic               m_tready;
    logic               m_tlast;
    logic [7:0]         c_tdata;
    logic               c_tvalid;
    logic               c_tready;
    logic               evt_short;
    logic               evt_missing;
    logic [15:0]        frame_cnt;
    logic [1:0]         dbg_state;

    // master: the framer; drives the output stream, config word and status
    modport master (
        input  s_tdata, s_tvalid, s_tlast, cfg_log2n, cfg_fwd, cfg_update,
               m_tready, c_tready,
        output s_tready, m_tdata, m_tvalid, m_tlast, c_tdata, c_tvalid,
               evt_short, evt_missing, frame_cnt, dbg_state
    );

    // slave: the surroundings (sample source, FFT core, monitoring)
    modport slave (
        output s_tdata, s_tvalid, s_tlast, cfg_log2n, cfg_fwd, cfg_update,
               m_tready, c_tready,
        input  s_tready, m_tdata, m_tvalid, m_tlast, c_tdata, c_tvalid,
               evt_short, evt_missing, frame_cnt, dbg_state
    );
endinterface

// File: rtl/fft_stream_framer.sv
// FFT front-end: packs real samples into complex words, frames them into
// N-point blocks with a generated tlast, zero-pads short frames, and sends a
// config word to the FFT core whenever size/direction change (frame boundary).
// The interface instance must use the same DATA_W/OUT_W as this module.
module fft_stream_framer #(
    parameter int DATA_W    = 16,
    parameter int OUT_W     = 16,
    parameter int MIN_LOG2N = 3,
    parameter int MAX_LOG2N = 12
) (
    input  logic                aclk,
    input  logic                aresetn,
    fft_stream_framer_if.master bus
);
    typedef enum logic [1:0] {
        ST_CFG    = 2'd0,
        ST_STREAM = 2'd1,
        ST_PAD    = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [4:0]           act_log2n_q, act_log2n_d, pend_log2n_q, pend_log2n_d;
    logic                 act_fwd_q, act_fwd_d, pend_fwd_q, pend_fwd_d;
    logic                 dirty_q, dirty_d;
    logic [MAX_LOG2N-1:0] cnt_q, cnt_d;
    logic [2*OUT_W-1:0]   m_tdata_q, m_tdata_d;
    logic                 m_tvalid_q, m_tvalid_d, m_tlast_q, m_tlast_d;
    logic [7:0]           c_tdata_q, c_tdata_d;
    logic                 c_tvalid_q, c_tvalid_d;
    logic                 evt_short_q, evt_short_d, evt_missing_q, evt_missing_d;
    logic [15:0]          frame_cnt_q, frame_cnt_d;

    logic [DATA_W-1:0]    s_data;
    logic signed [OUT_W-1:0] real_ext;
    logic [4:0]           clamp_log2n;
    logic [MAX_LOG2N-1:0] nm1;
    logic                 out_free, s_acc, at_last, cfg_hs, dirty_now;

    // Clamp requested size and track the pending (not yet sent) config
    always_comb begin
        clamp_log2n = bus.cfg_log2n;
        if (bus.cfg_log2n < 5'(MIN_LOG2N))
            clamp_log2n = 5'(MIN_LOG2N);
        else if (bus.cfg_log2n > 5'(MAX_LOG2N))
            clamp_log2n = 5'(MAX_LOG2N);
        pend_log2n_d = pend_log2n_q;
        pend_fwd_d   = pend_fwd_q;
        if (bus.cfg_update) begin
            pend_log2n_d = clamp_log2n;
            pend_fwd_d   = bus.cfg_fwd;
        end
    end

    // Next-state and datapath: framing FSM, output register, config snapshot
    always_comb begin
        s_data    = bus.s_tdata;
        real_ext  = OUT_W'(signed'(s_data));
        out_free  = !m_tvalid_q || bus.m_tready;
        s_acc     = (state_q == ST_STREAM) && out_free && bus.s_tvalid;
        nm1       = MAX_LOG2N'((32'd1 << act_log2n_q) - 32'd1);
        at_last   = (cnt_q == nm1);
        cfg_hs    = c_tvalid_q && bus.c_tready;
        dirty_now = dirty_q || bus.cfg_update;

        state_d       = state_q;
        act_log2n_d   = act_log2n_q;
        act_fwd_d     = act_fwd_q;
        dirty_d       = dirty_now;
        cnt_d         = cnt_q;
        m_tdata_d     = m_tdata_q;
        m_tvalid_d    = m_tvalid_q;
        m_tlast_d     = m_tlast_q;
        c_tdata_d     = c_tdata_q;
        c_tvalid_d    = c_tvalid_q;
        evt_short_d   = 1'b0;
        evt_missing_d = 1'b0;
        frame_cnt_d   = frame_cnt_q + 16'(m_tvalid_q && bus.m_tready && m_tlast_q);

        if (m_tvalid_q && bus.m_tready)
            m_tvalid_d = 1'b0;

        case (state_q)
            ST_CFG: begin
                if (cfg_hs) begin
                    act_log2n_d = c_tdata_q[4:0];
                    act_fwd_d   = c_tdata_q[5];
                    state_d     = dirty_now ? ST_CFG : ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (s_acc) begin
                    m_tdata_d  = {{OUT_W{1'b0}}, real_ext};
                    m_tvalid_d = 1'b1;
                    m_tlast_d  = at_last;
                    cnt_d      = at_last ? '0 : cnt_q + MAX_LOG2N'(1);
                    if (at_last) begin
                        evt_missing_d = !bus.s_tlast;
                        state_d       = dirty_now ? ST_CFG : ST_STREAM;
                    end else if (bus.s_tlast) begin
                        evt_short_d = 1'b1;
                        state_d     = ST_PAD;
                    end
                end
            end
            ST_PAD: begin
                if (out_free) begin
                    m_tdata_d  = '0;
                    m_tvalid_d = 1'b1;
                    m_tlast_d  = at_last;
                    cnt_d      = at_last ? '0 : cnt_q + MAX_LOG2N'(1);
                    if (at_last)
                        state_d = dirty_now ? ST_CFG : ST_STREAM;
                end
            end
            default: state_d = ST_CFG;
        endcase

        // The config word is a snapshot so it stays stable while c_tready is
        // low; a change arriving after the snapshot leaves dirty set and the
        // FSM re-enters CFG for a follow-up transaction.
        if ((state_d == ST_CFG) && (!c_tvalid_q || cfg_hs)) begin
            c_tdata_d  = {2'b00, pend_fwd_d, pend_log2n_d};
            c_tvalid_d = 1'b1;
            dirty_d    = 1'b0;
        end else if (cfg_hs) begin
            c_tvalid_d = 1'b0;
        end
    end

    // State registers; reset lands in CFG so a config is always sent first
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= ST_CFG;
            act_log2n_q   <= 5'(MIN_LOG2N);
            act_fwd_q     <= 1'b1;
            pend_log2n_q  <= 5'(MIN_LOG2N);
            pend_fwd_q    <= 1'b1;
            dirty_q       <= 1'b0;
            cnt_q         <= '0;
            m_tdata_q     <= '0;
            m_tvalid_q    <= 1'b0;
            m_tlast_q     <= 1'b0;
            c_tdata_q     <= '0;
            c_tvalid_q    <= 1'b0;
            evt_short_q   <= 1'b0;
            evt_missing_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            act_log2n_q   <= act_log2n_d;
            act_fwd_q     <= act_fwd_d;
            pend_log2n_q  <= pend_log2n_d;
            pend_fwd_q    <= pend_fwd_d;
            dirty_q       <= dirty_d;
            cnt_q         <= cnt_d;
            m_tdata_q     <= m_tdata_d;
            m_tvalid_q    <= m_tvalid_d;
            m_tlast_q     <= m_tlast_d;
            c_tdata_q     <= c_tdata_d;
            c_tvalid_q    <= c_tvalid_d;
            evt_short_q   <= evt_short_d;
            evt_missing_q <= evt_missing_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign bus.s_tready    = (state_q == ST_STREAM) && out_free;
    assign bus.m_tdata     = m_tdata_q;
    assign bus.m_tvalid    = m_tvalid_q;
    assign bus.m_tlast     = m_tlast_q;
    assign bus.c_tdata     = c_tdata_q;
    assign bus.c_tvalid    = c_tvalid_q;
    assign bus.evt_short   = evt_short_q;
    assign bus.evt_missing = evt_missing_q;
    assign bus.frame_cnt   = frame_cnt_q;
    assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_fft_stream_framer.sv
// Directed bench for fft_stream_framer: framing, padding, config sequencing,
// sign extension (second instance with 12-bit samples) and reset behaviour.
module tb_fft_stream_framer;
    logic aclk;
    logic aresetn;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [31:0] got_data_q[$];
    logic        got_last_q[$];
    int          got_ncfg_q[$];
    logic [7:0]  got_cfg_q[$];
    int          short_cnt   = 0;
    int          missing_cnt = 0;
    logic [31:0] exp_q[$];
    logic        exp_last_q[$];
    logic        rand_rdy = 1'b0;

    fft_stream_framer_if #(.DATA_W(16), .OUT_W(16)) bus ();
    fft_stream_framer_if #(.DATA_W(12), .OUT_W(16)) bus12 ();

    fft_stream_framer #(.DATA_W(16), .OUT_W(16), .MIN_LOG2N(3), .MAX_LOG2N(12)) dut (
        .aclk(aclk), .aresetn(aresetn), .bus(bus));
    fft_stream_framer #(.DATA_W(12), .OUT_W(16), .MIN_LOG2N(3), .MAX_LOG2N(12)) dut12 (
        .aclk(aclk), .aresetn(aresetn), .bus(bus12));

    // Clock / reset
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Downstream ready: always high, or random while rand_rdy is set
    always @(posedge aclk) begin
        #1;
        bus.m_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: record transfers mid-cycle, when every signal is settled
    always @(negedge aclk) begin
        if (aresetn) begin
            if (bus.m_tvalid && bus.m_tready) begin
                got_data_q.push_back(bus.m_tdata);
                got_last_q.push_back(bus.m_tlast);
                got_ncfg_q.push_back(got_cfg_q.size());
            end
            if (bus.c_tvalid && bus.c_tready) got_cfg_q.push_back(bus.c_tdata);
            if (bus.evt_short) short_cnt++;
            if (bus.evt_missing) missing_cnt++;
        end
    end

    // Driver: present one sample and hold it until accepted (call at posedge+1)
    task automatic send_sample(input logic [15:0] d, input logic l);
        bit hs = 1'b0;
        int n  = 0;
        bus.s_tdata  = d;
        bus.s_tlast  = l;
        bus.s_tvalid = 1'b1;
        while (!hs && n < 200) begin
            @(negedge aclk);
            hs = bus.s_tready;
            @(posedge aclk);
            #1;
            n++;
        end
        bus.s_tvalid = 1'b0;
        bus.s_tlast  = 1'b0;
        if (!hs) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: s_tready stayed low for %0d cycles, required a transfer", n);
        end
    endtask

    task automatic pulse_cfg(input logic [4:0] log2n, input logic fwd);
        bus.cfg_log2n  = log2n;
        bus.cfg_fwd    = fwd;
        bus.cfg_update = 1'b1;
        @(posedge aclk);
        #1;
        bus.cfg_update = 1'b0;
    endtask

    // Bounded waits; the callers compare the resulting queue sizes
    task automatic wait_words(input int target);
        for (int i = 0; i < 400 && got_data_q.size() < target; i++) begin
            @(posedge aclk);
            #1;
        end
        repeat (4) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic wait_cfg(input int target);
        for (int i = 0; i < 50 && got_cfg_q.size() < target; i++) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic test_reset;
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        n_tests++;
        if ({bus.s_tready, bus.m_tvalid, bus.m_tlast, bus.c_tvalid, bus.evt_short, bus.evt_missing,
             bus.m_tdata, bus.c_tdata, bus.frame_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: m_tvalid=%b m_tdata=%h c_tvalid=%b c_tdata=%h s_tready=%b frame_cnt=%0d, required all 0",
                     bus.m_tvalid, bus.m_tdata, bus.c_tvalid, bus.c_tdata, bus.s_tready, bus.frame_cnt);
        end
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        wait_cfg(1);
        n_tests++;
        if (got_cfg_q.size() != 1 || got_cfg_q[0] !== 8'h23) begin
            n_fail++;
            $display("FAIL reset_cfg: %0d configs, first=%h, required 1 config 23",
                     got_cfg_q.size(), (got_cfg_q.size() > 0) ? got_cfg_q[0] : 8'hxx);
        end
    endtask

    task automatic test_basic;
        int wb = got_data_q.size();
        int sb = short_cnt;
        int mb = missing_cnt;
        exp_q.delete();
        exp_last_q.delete();
        for (int i = 1; i <= 8; i++) begin
            exp_q.push_back(32'(i));
            exp_last_q.push_back(i == 8);
        end
        for (int i = 1; i <= 8; i++) send_sample(16'(i), i == 8);
        wait_words(wb + 8);
        n_tests++;
        if (got_data_q.size() != wb + exp_q.size()) begin
            n_fail++;
            $display("FAIL basic_count: got %0d words, required %0d", got_data_q.size() - wb, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_tests++;
                if (got_data_q[wb+i] !== exp_q[i] || got_last_q[wb+i] !== exp_last_q[i]) begin
                    n_fail++;
                    $display("FAIL basic_word%0d: got %h last=%b, required %h last=%b",
                             i, got_data_q[wb+i], got_last_q[wb+i], exp_q[i], exp_last_q[i]);
                end
            end
        end
        n_tests++;
        if (bus.frame_cnt !== 16'd1 || short_cnt != sb || missing_cnt != mb) begin
            n_fail++;
            $display("FAIL basic_status: frame_cnt=%0d short=%0d missing=%0d, required 1 0 0",
                     bus.frame_cnt, short_cnt - sb, missing_cnt - mb);
        end
    endtask

    task automatic test_sign_extend;
        logic [11:0] vec [2];
        logic [31:0] exp [2];
        vec[0] = 12'h800; exp[0] = 32'h0000F800;
        vec[1] = 12'h7FF; exp[1] = 32'h000007FF;
        for (int k = 0; k < 2; k++) begin
            bit hs = 1'b0;
            int n  = 0;
            bus12.s_tdata  = vec[k];
            bus12.s_tvalid = 1'b1;
            while (!hs && n < 50) begin
                @(negedge aclk);
                hs = bus12.s_tready;
                @(posedge aclk);
                #1;
                n++;
            end
            bus12.s_tvalid = 1'b0;
            @(negedge aclk);
            n_tests++;
            if (!hs || bus12.m_tvalid !== 1'b1 || bus12.m_tdata !== exp[k]) begin
                n_fail++;
                $display("FAIL sext_%h: m_tvalid=%b m_tdata=%h, required 1 %h", vec[k], bus12.m_tvalid, bus12.m_tdata, exp[k]);
            end
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic test_cfg_change;
        int wb = got_data_q.size();
        int cb = got_cfg_q.size();
        exp_q.delete();
        exp_last_q.delete();
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(32'h10 + 32'(i));
            exp_last_q.push_back(i == 7);
        end
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(32'h40 + 32'(i));
            exp_last_q.push_back(i == 15);
        end
        for (int i = 0; i < 8; i++) begin
            send_sample(16'h10 + 16'(i), i == 7);
            if (i == 2) pulse_cfg(5'd4, 1'b0);
        end
        for (int i = 0; i < 16; i++) begin
            send_sample(16'h40 + 16'(i), i == 15);
            if (i == 0) pulse_cfg(5'd1, 1'b1);
        end
        wait_words(wb + 24);
        n_tests++;
        if (got_data_q.size() != wb + exp_q.size()) begin
            n_fail++;
            $display("FAIL cfg_count: got %0d words, required %0d", got_data_q.size() - wb, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_tests++;
                if (got_data_q[wb+i] !== exp_q[i] || got_last_q[wb+i] !== exp_last_q[i]) begin
                    n_fail++;
                    $display("FAIL cfg_word%0d: got %h last=%b, required %h last=%b",
                             i, got_data_q[wb+i], got_last_q[wb+i], exp_q[i], exp_last_q[i]);
                end
            end
            n_tests++;
            if (got_ncfg_q[wb+7] - cb != 0 || got_ncfg_q[wb+8] - cb != 1) begin
                n_fail++;
                $display("FAIL cfg_order: configs before word7=%0d word8=%0d, required 0 1",
                         got_ncfg_q[wb+7] - cb, got_ncfg_q[wb+8] - cb);
            end
        end
        n_tests++;
        if (got_cfg_q.size() != cb + 2 || got_cfg_q[cb] !== 8'h04 || got_cfg_q[cb+1] !== 8'h23) begin
            n_fail++;
            $display("FAIL cfg_words: %0d configs, required 2 (04 then 23 after clamp)", got_cfg_q.size() - cb);
        end
        n_tests++;
        if (bus.frame_cnt !== 16'd3) begin
            n_fail++;
            $display("FAIL cfg_frame_cnt: got %0d, required 3", bus.frame_cnt);
        end
    endtask

    task automatic test_short_frame;
        int wb = got_data_q.size();
        int sb = short_cnt;
        int mb = missing_cnt;
        exp_q = '{32'h0011, 32'h0022, 32'h0000FFFD, 0, 0, 0, 0, 0};
        exp_last_q = '{0, 0, 0, 0, 0, 0, 0, 1};
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(32'h50 + 32'(i));
            exp_last_q.push_back(i == 7);
        end
        send_sample(16'h0011, 1'b0);
        send_sample(16'h0022, 1'b0);
        send_sample(16'hFFFD, 1'b1);
        @(negedge aclk);
        n_tests++;
        if (bus.s_tready !== 1'b0) begin
            n_fail++;
            $display("FAIL pad_s_tready: got %b, required 0", bus.s_tready);
        end
        @(posedge aclk);
        #1;
        for (int i = 0; i < 8; i++) send_sample(16'h50 + 16'(i), i == 7);
        wait_words(wb + 16);
        n_tests++;
        if (got_data_q.size() != wb + exp_q.size()) begin
            n_fail++;
            $display("FAIL short_count: got %0d words, required %0d", got_data_q.size() - wb, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_tests++;
                if (got_data_q[wb+i] !== exp_q[i] || got_last_q[wb+i] !== exp_last_q[i]) begin
                    n_fail++;
                    $display("FAIL short_word%0d: got %h last=%b, required %h last=%b",
                             i, got_data_q[wb+i], got_last_q[wb+i], exp_q[i], exp_last_q[i]);
                end
            end
        end
        n_tests++;
        if (bus.frame_cnt !== 16'd5 || short_cnt - sb != 1 || missing_cnt != mb) begin
            n_fail++;
            $display("FAIL short_status: frame_cnt=%0d short=%0d missing=%0d, required 5 1 0",
                     bus.frame_cnt, short_cnt - sb, missing_cnt - mb);
        end
    endtask

    task automatic test_missing_last;
        int wb = got_data_q.size();
        int sb = short_cnt;
        int mb = missing_cnt;
        exp_q.delete();
        exp_last_q.delete();
        for (int i = 1; i <= 16; i++) begin
            exp_q.push_back(32'h100 + 32'(i));
            exp_last_q.push_back(i == 8 || i == 16);
        end
        for (int i = 1; i <= 16; i++) send_sample(16'h100 + 16'(i), i == 16);
        wait_words(wb + 16);
        n_tests++;
        if (got_data_q.size() != wb + exp_q.size()) begin
            n_fail++;
            $display("FAIL missing_count: got %0d words, required %0d", got_data_q.size() - wb, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_tests++;
                if (got_data_q[wb+i] !== exp_q[i] || got_last_q[wb+i] !== exp_last_q[i]) begin
                    n_fail++;
                    $display("FAIL missing_word%0d: got %h last=%b, required %h last=%b",
                             i, got_data_q[wb+i], got_last_q[wb+i], exp_q[i], exp_last_q[i]);
                end
            end
        end
        n_tests++;
        if (bus.frame_cnt !== 16'd7 || short_cnt != sb || missing_cnt - mb != 1) begin
            n_fail++;
            $display("FAIL missing_status: frame_cnt=%0d short=%0d missing=%0d, required 7 0 1",
                     bus.frame_cnt, short_cnt - sb, missing_cnt - mb);
        end
    endtask

    task automatic test_back_to_back_reset;
        int wb = got_data_q.size();
        int cb;
        exp_q.delete();
        exp_last_q.delete();
        for (int i = 0; i < 12; i++) begin
            exp_q.push_back(32'h200 + 32'(i));
            exp_last_q.push_back(i == 7);
        end
        rand_rdy = 1'b1;
        for (int i = 0; i < 12; i++) send_sample(16'h200 + 16'(i), i == 7);
        wait_words(wb + 12);
        rand_rdy = 1'b0;
        n_tests++;
        if (got_data_q.size() != wb + exp_q.size()) begin
            n_fail++;
            $display("FAIL bp_count: got %0d words, required %0d", got_data_q.size() - wb, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_tests++;
                if (got_data_q[wb+i] !== exp_q[i] || got_last_q[wb+i] !== exp_last_q[i]) begin
                    n_fail++;
                    $display("FAIL bp_word%0d: got %h last=%b, required %h last=%b",
                             i, got_data_q[wb+i], got_last_q[wb+i], exp_q[i], exp_last_q[i]);
                end
            end
        end
        n_tests++;
        if (bus.frame_cnt !== 16'd8) begin
            n_fail++;
            $display("FAIL bp_frame_cnt: got %0d, required 8", bus.frame_cnt);
        end
        // reset in the middle of the second frame (4 of 8 samples sent)
        aresetn = 1'b0;
        @(negedge aclk);
        n_tests++;
        if ({bus.s_tready, bus.m_tvalid, bus.m_tlast, bus.c_tvalid, bus.evt_short, bus.evt_missing,
             bus.m_tdata, bus.c_tdata, bus.frame_cnt} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: m_tvalid=%b c_tvalid=%b c_tdata=%h s_tready=%b frame_cnt=%0d, required all 0",
                     bus.m_tvalid, bus.c_tvalid, bus.c_tdata, bus.s_tready, bus.frame_cnt);
        end
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        cb = got_cfg_q.size();
        wait_cfg(cb + 1);
        n_tests++;
        if (got_cfg_q.size() != cb + 1 || got_cfg_q[cb] !== 8'h23) begin
            n_fail++;
            $display("FAIL midreset_cfg: %0d new configs, required 1 config 23", got_cfg_q.size() - cb);
        end
        wb = got_data_q.size();
        for (int i = 0; i < 8; i++) send_sample(16'h300 + 16'(i), i == 7);
        wait_words(wb + 8);
        n_tests++;
        if (got_data_q.size() != wb + 8 || got_last_q[wb+7] !== 1'b1 || got_last_q[wb+6] !== 1'b0
            || got_data_q[wb] !== 32'h300 || bus.frame_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL midreset_frame: words=%0d frame_cnt=%0d, required 8 words, tlast on 8th, frame_cnt 1",
                     got_data_q.size() - wb, bus.frame_cnt);
        end
    endtask

    // Sequence of scenarios and final report
    initial begin
        aresetn          = 1'b0;
        bus.s_tdata      = '0;
        bus.s_tvalid     = 1'b0;
        bus.s_tlast      = 1'b0;
        bus.cfg_log2n    = 5'd3;
        bus.cfg_fwd      = 1'b1;
        bus.cfg_update   = 1'b0;
        bus.c_tready     = 1'b1;
        bus12.s_tdata    = '0;
        bus12.s_tvalid   = 1'b0;
        bus12.s_tlast    = 1'b0;
        bus12.cfg_log2n  = 5'd3;
        bus12.cfg_fwd    = 1'b1;
        bus12.cfg_update = 1'b0;
        bus12.c_tready   = 1'b1;
        bus12.m_tready   = 1'b1;
        test_reset();
        test_basic();
        test_sign_extend();
        test_cfg_change();
        test_short_frame();
        test_missing_last();
        test_back_to_back_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time bound
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
